// File: rtl/dac_pkg.sv
// Shared definitions for the PmodDA2 serializer: FSM states, frame geometry
// and the DAC121S101 power-down mode encodings.
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_W     = 12;

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [1:0]        pd,
        input logic [DATA_W-1:0] data
    );
        return {2'b00, pd, data};
    endfunction

endpackage

// File: rtl/pmod_da2_sclk_gen.sv
// SCLK generator: registered serial clock idling high, plus strobes marking
// the clock edges on which SCLK falls or rises.
module pmod_da2_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             sclk_r;
    logic             wrap_s;

    // The strobes are valid on the edge where SCLK is about to toggle.
    assign wrap_s    = en && (cnt_r == CNT_MAX);
    assign fall_tick = wrap_s && sclk_r;
    assign rise_tick = wrap_s && !sclk_r;
    assign sclk      = sclk_r;

    // Half-period counter and SCLK register; disabled means parked high.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= 1'b1;
        end else if (!en) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= 1'b1;
        end else if (wrap_s) begin
            cnt_r  <= {CNT_W{1'b0}};
            sclk_r <= ~sclk_r;
        end else begin
            cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pmod_da2_serializer.sv
// Dual-channel PmodDA2 serializer: latches a sample pair on VALID/READY and
// shifts two 16-bit frames MSB-first under shared SCLK/SYNCn.
module pmod_da2_serializer
    import dac_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int SYNC_HIGH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              VALID,
    output logic              READY,
    input  logic [DATA_W-1:0] DATAINA,
    input  logic [DATA_W-1:0] DATAINB,
    input  logic [1:0]        PD,
    output logic              DONE,
    output logic              SCLK,
    output logic              SYNCn,
    output logic              DINA,
    output logic              DINB
);

    localparam int GAP_W = $clog2(SYNC_HIGH + 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(SYNC_HIGH - 1);
    localparam logic [4:0]       BITS_END = 5'(FRAME_BITS);

    state_t                 state_r, state_next_s;
    logic [4:0]             bit_cnt_r, bit_cnt_next_s;
    logic [GAP_W-1:0]       gap_cnt_r, gap_cnt_next_s;
    logic [FRAME_BITS-1:0]  sh_a_r, sh_a_next_s, sh_b_r, sh_b_next_s;
    logic [FRAME_BITS-1:0]  frame_a_s, frame_b_s;
    logic                   ready_r, ready_next_s;
    logic                   done_r, done_next_s;
    logic                   sync_n_r, sync_n_next_s;
    logic                   dina_r, dina_next_s;
    logic                   dinb_r, dinb_next_s;
    logic                   sclk_en_s, rise_tick_s, fall_tick_s;

    assign frame_a_s = make_frame(PD, DATAINA);
    assign frame_b_s = make_frame(PD, DATAINB);
    assign sclk_en_s = (state_r == SHIFT);

    pmod_da2_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk       (Clk),
        .rst       (Rst),
        .en        (sclk_en_s),
        .sclk      (SCLK),
        .rise_tick (rise_tick_s),
        .fall_tick (fall_tick_s)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_next_s   = state_r;
        bit_cnt_next_s = bit_cnt_r;
        gap_cnt_next_s = gap_cnt_r;
        sh_a_next_s    = sh_a_r;
        sh_b_next_s    = sh_b_r;
        ready_next_s   = ready_r;
        done_next_s    = 1'b0;
        sync_n_next_s  = sync_n_r;
        dina_next_s    = dina_r;
        dinb_next_s    = dinb_r;
        case (state_r)
            IDLE: begin
                ready_next_s  = 1'b1;
                sync_n_next_s = 1'b1;
                dina_next_s   = 1'b0;
                dinb_next_s   = 1'b0;
                if (VALID && ready_r) begin
                    state_next_s   = SHIFT;
                    ready_next_s   = 1'b0;
                    sync_n_next_s  = 1'b0;
                    bit_cnt_next_s = 5'd0;
                    dina_next_s    = frame_a_s[FRAME_BITS-1];
                    dinb_next_s    = frame_b_s[FRAME_BITS-1];
                    sh_a_next_s    = {frame_a_s[FRAME_BITS-2:0], 1'b0};
                    sh_b_next_s    = {frame_b_s[FRAME_BITS-2:0], 1'b0};
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (fall_tick_s) begin
                    bit_cnt_next_s = bit_cnt_r + 5'd1;
                end else if (rise_tick_s) begin
                    // Rising edge after the 16th low phase closes the frame.
                    if (bit_cnt_r == BITS_END) begin
                        state_next_s   = GAP;
                        sync_n_next_s  = 1'b1;
                        done_next_s    = 1'b1;
                        dina_next_s    = 1'b0;
                        dinb_next_s    = 1'b0;
                        gap_cnt_next_s = {GAP_W{1'b0}};
                    end else begin
                        dina_next_s = sh_a_r[FRAME_BITS-1];
                        dinb_next_s = sh_b_r[FRAME_BITS-1];
                        sh_a_next_s = {sh_a_r[FRAME_BITS-2:0], 1'b0};
                        sh_b_next_s = {sh_b_r[FRAME_BITS-2:0], 1'b0};
                    end
                end else begin
                    state_next_s = SHIFT;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_MAX) begin
                    state_next_s = IDLE;
                    ready_next_s = 1'b1;
                end else begin
                    gap_cnt_next_s = gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s  = IDLE;
                ready_next_s  = 1'b1;
                sync_n_next_s = 1'b1;
                dina_next_s   = 1'b0;
                dinb_next_s   = 1'b0;
            end
        endcase
    end

    // State, counters, shift registers and pin registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r   <= IDLE;
            bit_cnt_r <= 5'd0;
            gap_cnt_r <= {GAP_W{1'b0}};
            sh_a_r    <= {FRAME_BITS{1'b0}};
            sh_b_r    <= {FRAME_BITS{1'b0}};
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            sync_n_r  <= 1'b1;
            dina_r    <= 1'b0;
            dinb_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            gap_cnt_r <= gap_cnt_next_s;
            sh_a_r    <= sh_a_next_s;
            sh_b_r    <= sh_b_next_s;
            ready_r   <= ready_next_s;
            done_r    <= done_next_s;
            sync_n_r  <= sync_n_next_s;
            dina_r    <= dina_next_s;
            dinb_r    <= dinb_next_s;
        end
    end

    assign READY = ready_r;
    assign DONE  = done_r;
    assign SYNCn = sync_n_r;
    assign DINA  = dina_r;
    assign DINB  = dinb_r;

endmodule

// File: tb/tb_pmod_da2_serializer.sv
// Directed bench for pmod_da2_serializer: a DAC-side monitor captures frames
// on SCLK falling edges and a scoreboard compares them with expected words.
module tb_pmod_da2_serializer;
    import dac_pkg::*;

    localparam int H  = 4;
    localparam int SH = 4;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        VALID;
    logic        READY;
    logic [11:0] DATAINA, DATAINB;
    logic [1:0]  PD;
    logic        DONE, SCLK, SYNCn, DINA, DINB;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int cur    = 0;

    logic [15:0] exp_a_q[$], exp_b_q[$], rx_a_q[$], rx_b_q[$];

    logic        prev_sclk = 1'b1, prev_sync = 1'b1;
    logic [15:0] mon_a = 16'h0, mon_b = 16'h0;
    int nbits = 0, done_cnt = 0, abort_cnt = 0, sync_low = 0, last_sync_low = 0;

    pmod_da2_serializer #(.CLK_DIV(H), .SYNC_HIGH(SH)) dut (
        .Clk(Clk), .Rst(Rst), .VALID(VALID), .READY(READY),
        .DATAINA(DATAINA), .DATAINB(DATAINB), .PD(PD), .DONE(DONE),
        .SCLK(SCLK), .SYNCn(SYNCn), .DINA(DINA), .DINB(DINB)
    );

    always #4 Clk = ~Clk;

    // DAC model: shift in on SCLK falls during SYNCn low, track frame timing.
    initial begin
        forever begin
            @(negedge Clk);
            if (!SYNCn) begin
                sync_low++;
                if (prev_sclk && !SCLK) begin
                    mon_a = {mon_a[14:0], DINA};
                    mon_b = {mon_b[14:0], DINB};
                    nbits++;
                    if (nbits == 16) begin
                        rx_a_q.push_back(mon_a);
                        rx_b_q.push_back(mon_b);
                    end
                end
            end
            if (!prev_sync && SYNCn) begin
                last_sync_low = sync_low;
                sync_low = 0;
                if (nbits != 16) abort_cnt++;
                nbits = 0;
            end
            if (DONE) done_cnt++;
            prev_sclk = SCLK;
            prev_sync = SYNCn;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the negedge preceding spec edge k of the current frame.
    task automatic goto(input int k);
        while (cur < k) begin
            @(negedge Clk);
            cur++;
        end
    endtask

    // Handshake; returns at spec edge 1. keep_valid leaves VALID high.
    task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [1:0] pd,
                        input bit push, input bit keep_valid);
        int n = 0;
        @(negedge Clk);
        while (!READY && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check("ready_before_send", {31'd0, READY}, 32'd1);
        VALID = 1'b1; DATAINA = a; DATAINB = b; PD = pd;
        if (push) begin
            exp_a_q.push_back({2'b00, pd, a});
            exp_b_q.push_back({2'b00, pd, b});
        end
        @(posedge Clk);
        @(negedge Clk);
        cur = 1;
        if (!keep_valid) VALID = 1'b0;
        DATAINA = ~a; DATAINB = ~b; PD = ~pd;
    endtask

    task automatic check_frames(input string tag);
        int n = 0;
        while (rx_a_q.size() < exp_a_q.size() && n < 400) begin
            @(negedge Clk);
            n++;
        end
        check({tag, "_count"}, rx_a_q.size(), exp_a_q.size());
        while (exp_a_q.size() > 0 && rx_a_q.size() > 0) begin
            check({tag, "_a"}, {16'd0, rx_a_q.pop_front()}, {16'd0, exp_a_q.pop_front()});
            check({tag, "_b"}, {16'd0, rx_b_q.pop_front()}, {16'd0, exp_b_q.pop_front()});
        end
        exp_a_q.delete(); exp_b_q.delete(); rx_a_q.delete(); rx_b_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sclk"},  {31'd0, SCLK},  32'd1);
        check({tag, "_syncn"}, {31'd0, SYNCn}, 32'd1);
        check({tag, "_dina"},  {31'd0, DINA},  32'd0);
        check({tag, "_dinb"},  {31'd0, DINB},  32'd0);
        check({tag, "_ready"}, {31'd0, READY}, 32'd1);
        check({tag, "_done"},  {31'd0, DONE},  32'd0);
    endtask

    initial begin
        int d0, a0, n;
        Rst = 1'b1; VALID = 1'b0; DATAINA = 12'h0; DATAINB = 12'h0; PD = PD_NORMAL;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_idle("reset");
        Rst = 1'b0;

        // Single frame with timing landmarks.
        d0 = done_cnt;
        send(12'hC93, 12'h895, PD_NORMAL, 1'b1, 1'b0);
        check("f1_ready_low",  {31'd0, READY}, 32'd0);
        check("f1_syncn_low",  {31'd0, SYNCn}, 32'd0);
        check("f1_sclk_high",  {31'd0, SCLK},  32'd1);
        goto(1 + H);
        check("f1_sclk_fall",  {31'd0, SCLK},  32'd0);
        goto(1 + 2 * H * 5);
        check("f1_bit10_a",    {31'd0, DINA},  32'd1);
        check("f1_bit10_b",    {31'd0, DINB},  32'd0);
        goto(32 * H);
        check("f1_syncn_last", {31'd0, SYNCn}, 32'd0);
        goto(1 + 32 * H);
        check("f1_syncn_rise", {31'd0, SYNCn}, 32'd1);
        check("f1_done",       {31'd0, DONE},  32'd1);
        check("f1_gap_sclk",   {31'd0, SCLK},  32'd1);
        goto(2 + 32 * H);
        check("f1_done_clear", {31'd0, DONE},  32'd0);
        goto(32 * H + SH);
        check("f1_ready_late", {31'd0, READY}, 32'd0);
        goto(1 + 32 * H + SH);
        check("f1_ready_back", {31'd0, READY}, 32'd1);
        check("f1_sync_len",   last_sync_low, 32 * H);
        check("f1_done_count", done_cnt - d0, 1);
        check_frames("f1");

        // PD field in bits 13:12.
        send(12'hFFF, 12'h000, PD_HIZ, 1'b1, 1'b0);
        goto(1 + 2 * H * 2);
        check("pd_bit13_a", {31'd0, DINA}, 32'd1);
        check("pd_bit13_b", {31'd0, DINB}, 32'd1);
        goto(1 + 32 * H + SH);
        check_frames("pd");

        // Back-to-back with VALID held and new data after the first handshake.
        send(12'h589, 12'h123, PD_NORMAL, 1'b1, 1'b1);
        DATAINA = 12'hAAA; DATAINB = 12'h456; PD = PD_NORMAL;
        exp_a_q.push_back(16'h0AAA);
        exp_b_q.push_back(16'h0456);
        goto(1 + 32 * H + SH);
        check("b2b_ready",  {31'd0, READY}, 32'd1);
        check("b2b_syncn_hi", {31'd0, SYNCn}, 32'd1);
        goto(2 + 32 * H + SH);
        check("b2b_syncn_fall", {31'd0, SYNCn}, 32'd0);
        check("b2b_ready_low",  {31'd0, READY}, 32'd0);
        VALID = 1'b0;
        goto(2 * (1 + 32 * H + SH));
        check_frames("b2b");

        // VALID while busy is ignored.
        d0 = done_cnt;
        send(12'h321, 12'h654, PD_1K, 1'b1, 1'b0);
        goto(10);
        VALID = 1'b1; DATAINA = 12'hFDF;
        goto(12);
        VALID = 1'b0;
        goto(1 + 32 * H + SH + 8);
        check("busy_ready", {31'd0, READY}, 32'd1);
        check("busy_syncn", {31'd0, SYNCn}, 32'd1);
        check("busy_done_count", done_cnt - d0, 1);
        check_frames("busy");

        // Reset after the fifth falling edge, then a clean frame.
        a0 = abort_cnt;
        send(12'h777, 12'h111, PD_NORMAL, 1'b0, 1'b0);
        n = 0;
        while (nbits < 5 && n < 200) begin
            @(negedge Clk);
            #1;
            n++;
        end
        check("mid_reached_5", nbits, 5);
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_idle("mid_reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        check("mid_abort", abort_cnt - a0, 1);
        send(12'hDBF, 12'h246, PD_100K, 1'b1, 1'b0);
        goto(1 + 32 * H + SH);
        check_frames("after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pmod_da2_serializer.md
# pmod_da2_serializer

Transmit-side counterpart of the ADC deserializer. It accepts two 12-bit samples through a valid/ready handshake and shifts them MSB-first as 16-bit frames to a dual-channel PmodDA2 (DAC121S101 ×2). The frames use a shared SCLK and SYNCn and one data line per channel. The block sits between the sample-processing logic and the DAC pins, in the same system-clock domain (125 MHz) as the deserializer.

## Interface
Parameters:
- CLK_DIV, 4: Clk cycles per SCLK half-period; SCLK = Clk/(2·CLK_DIV); legal ≥ 2.
- SYNC_HIGH, 4: Clk cycles SYNCn is held high after a frame before READY reasserts; legal ≥ 1.

Ports:
- Clk, input, 1: system clock. One clock only.
- Rst, input, 1: reset. Synchronous, active-high.
- VALID, input, 1: sample pair on DATAINA/DATAINB/PD is valid.
- READY, output, 1: block idle; a transfer occurs on any Clk edge with VALID && READY.
- DATAINA, input, 12: channel A sample, unsigned.
- DATAINB, input, 12: channel B sample, unsigned.
- PD, input, 2: DAC power-down mode bits, shared by both channels (00 = normal).
- DONE, output, 1: one-cycle pulse in the cycle SYNCn returns high at frame end.
- SCLK, output, 1: serial clock to the DAC; idles high.
- SYNCn, output, 1: frame sync, active-low.
- DINA, output, 1: channel A serial data.
- DINB, output, 1: channel B serial data.

## Operation
- Frame word, 16 bits, MSB first: [15:14] = 2'b00, [13:12] = PD, [11:0] = data.
- On the handshake, the A word, the B word and PD are latched into two 16-bit shift registers. Input changes after the handshake have no effect until the next handshake.
- FSM states:
  - IDLE: READY = 1, SYNCn = 1, SCLK = 1, DINx = 0. VALID → SHIFT.
  - SHIFT: SYNCn = 0. SCLK alternates between a high half-period and a low half-period, each CLK_DIV cycles long, starting high.
    - DINx changes only at the start of a high phase, when a new bit is presented.
    - The DAC samples DINx on the SCLK falling edge.
    - The block counts 16 low phases, then goes to GAP.
  - GAP: SYNCn = 1, SCLK = 1, DINx = 0. The block holds for SYNC_HIGH cycles, then goes to IDLE. DONE pulses in the first GAP cycle.
- VALID is ignored while READY = 0. Nothing is queued.
- Rst takes precedence in every state. On the next edge, the block goes to IDLE with all outputs at their reset values. If SYNCn rises before the 16th falling edge, the DAC aborts the partial write, and this is the accepted outcome.
- Every output is registered, so there are no combinational glitches on the pins.

## Timing
- Reset values: READY = 1, DONE = 0, SCLK = 1, SYNCn = 1, DINA = 0, DINB = 0.
- Handshake at edge 0 gives the following, with H = CLK_DIV:
  - Edge 1: READY = 0, SYNCn = 0, SCLK = 1, DINx = bit15.
  - Bit k (k = 15..0):
    - SCLK high for H cycles, starting at edge 1 + 2H(15−k).
    - SCLK falls at edge 1 + 2H(15−k) + H.
  - Edge 1 + 32H: SYNCn = 1, SCLK = 1, DONE = 1.
  - Edge 1 + 32H + SYNC_HIGH: READY = 1.
- Defaults: SCLK = 15.625 MHz. SYNCn is low for 128 cycles. READY is low for 132 cycles. A new handshake is possible at edge 133.
- Setup and hold of DINx around the falling edge is H cycles each, which is 32 ns at the defaults and meets the DAC's 5 ns / 4.5 ns requirement.
- Back-to-back: if VALID is held high, the next frame's SYNCn falls one cycle after READY reasserts.

## Structure
- Shared package dac_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - FRAME_BITS = 16, DATA_W = 12;
  - PD mode constants PD_NORMAL = 2'b00, PD_1K = 2'b01, PD_100K = 2'b10, PD_HIZ = 2'b11.
- One sub-module: pmod_da2_sclk_gen.
  - Half-period counter (width $clog2(CLK_DIV)).
  - Enabled in SHIFT; produces registered SCLK and the rise/fall tick strobes used by the FSM.
- The top module holds the FSM, the bit counter (0..16), the GAP counter and the two shift registers.

## Test plan
- Reset: Rst = 1 for 3 cycles during an active frame → next edge SCLK = 1, SYNCn = 1, DINA = DINB = 0, READY = 1, DONE = 0.
- Single frame: A = 0xC93, B = 0x895, PD = 00 → bench samples DINx on the 16 SCLK falling edges while SYNCn = 0 and reads 0x0C93 / 0x0895. SYNCn is low 128 cycles, DONE pulses once, READY returns at edge 133.
- PD field: PD = 2'b11, A = 0xFFF, B = 0x000 → sampled words 0x3FFF / 0x3000.
- Back-to-back: VALID held high; A = 0x589, then 0xAAA presented from the cycle after the first handshake → first frame carries 0x589 unchanged, second frame SYNCn falls one cycle after READY reasserts and carries 0xAAA.
- Busy: VALID pulses while READY = 0 with A = 0xFDF → ignored; exactly one frame and one DONE pulse occur.
- Mid-frame reset: Rst asserted after the 5th falling edge → next edge IDLE values. A following handshake with A = 0xDBF sends a complete, correct 0x0DBF frame.
